// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch stage.
//   InstrNop      - canonical NOP (addi x0, x0, 0) written into IF/ID on a flush
//   fetch_state_e - fetch control states
//   align_pc      - force a target address onto a word boundary
package fetch_unit_pkg;

    localparam logic [31:0] InstrNop = 32'h0000_0013;

    // StFetch: request outstanding at pc
    // StHold : response buffered locally while IF/ID is stalled, no request
    // StDrop : a request issued before a redirect is still outstanding
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrop  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID pipeline register.
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   flush_i          - kill the entry: valid=0, instr=NOP, pc kept (highest priority)
//   load_i           - capture {1, load_pc_i, load_instr_i}
//   bubble_i         - clear valid only, pc/instr kept
//   (none asserted)  - hold
//   id_valid_o/id_pc_o/id_instr_o - register contents
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] load_pc_i,
    input  logic [31:0] load_instr_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = InstrNop;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = load_pc_i;
            instr_d = load_instr_i;
        end else if (bubble_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= InstrNop;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign id_valid_o = valid_q;
    assign id_pc_o    = pc_q;
    assign id_instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, fetches over a req/ack
// handshake and fills the IF/ID register.
//   clk, rstn            - clock, asynchronous active-low reset
//   stall                - hold IF/ID and PC
//   redirect/redirect_pc - taken branch/jump from EX; flushes IF/ID
//   imem_req/imem_addr   - fetch request (address stable until ack)
//   imem_ack/imem_rdata  - fetch response
//   id_valid/id_pc/id_instr - IF/ID register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_addr_q, stale_addr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;

    logic         ifid_load;
    logic         ifid_bubble;
    logic         ifid_flush;
    logic [31:0]  ifid_pc;
    logic [31:0]  ifid_instr;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_addr_d = stale_addr_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        ifid_pc      = pc_q;
        ifid_instr   = imem_rdata;

        if (redirect) begin
            // Redirect wins over stall; any buffered instruction is abandoned
            // simply by leaving StHold.
            pc_d       = align_pc(redirect_pc);
            ifid_flush = 1'b1;
            unique case (state_q)
                StFetch: begin
                    if (!imem_ack) begin
                        state_d      = StDrop;
                        stale_addr_d = pc_q;
                    end
                end
                StHold:  state_d = StFetch;
                StDrop: begin
                    if (imem_ack) state_d = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        if (stall) begin
                            buf_pc_d    = pc_q;
                            buf_instr_d = imem_rdata;
                            state_d     = StHold;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_q + 32'd4;
                        end
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_pc    = buf_pc_q;
                        ifid_instr = buf_instr_q;
                        pc_d       = buf_pc_q + 32'd4;
                        state_d    = StFetch;
                    end
                end
                StDrop: begin
                    // Stale response is thrown away; pc already holds the target.
                    if (imem_ack) state_d = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            stale_addr_q <= RESET_PC;
            buf_pc_q     <= 32'h0;
            buf_instr_q  <= InstrNop;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_addr_q <= stale_addr_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    // Gated by rstn so no request is visible while reset is held.
    assign imem_req  = rstn && (state_q != StHold);
    assign imem_addr = (state_q == StDrop) ? stale_addr_q : pc_q;

    fetch_unit_if_id_reg u_if_id_reg (
        .clk_i        (clk),
        .rst_ni       (rstn),
        .flush_i      (ifid_flush),
        .load_i       (ifid_load),
        .bubble_i     (ifid_bubble),
        .load_pc_i    (ifid_pc),
        .load_instr_i (ifid_instr),
        .id_valid_o   (id_valid),
        .id_pc_o      (id_pc),
        .id_instr_o   (id_instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomised stimulus against a transaction-level
// model of the fetch stage; outputs compared every falling edge.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Model: pc of next fetch, pending stale request, queue of parked
    // responses, and the IF/ID contents.
    logic [31:0] m_pc, m_stale_addr, m_ipc, m_instr;
    bit          m_stale, m_valid;
    logic [63:0] m_bq[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    function automatic void m_reset();
        m_pc = 32'h0; m_stale = 1'b0; m_stale_addr = 32'h0;
        m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
        m_bq.delete();
    endfunction

    function automatic logic m_req();
        return rstn && (m_bq.size() == 0);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge using the inputs presented
    // before it, then return 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rstn) begin
            m_reset();
        end else if (redirect) begin
            if (m_req() && !m_stale && !imem_ack) begin
                m_stale = 1'b1;
                m_stale_addr = m_pc;
            end else if (m_stale && imem_ack) begin
                m_stale = 1'b0;
            end
            m_bq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (m_bq.size() != 0) begin
            if (!stall) begin
                m_ipc = m_bq[0][63:32];
                m_instr = m_bq[0][31:0];
                m_valid = 1'b1;
                m_pc = m_ipc + 32'd4;
                m_bq.delete();
            end
        end else if (m_stale) begin
            if (imem_ack) m_stale = 1'b0;
        end else if (imem_ack) begin
            if (stall) begin
                m_bq.push_back({m_pc, imem_rdata});
            end else begin
                m_valid = 1'b1;
                m_ipc = m_pc;
                m_instr = imem_rdata;
                m_pc = m_pc + 32'd4;
            end
        end else if (!stall) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic cyc(input bit ack, input bit st, input bit rd,
                       input logic [31:0] rpc, input logic [31:0] rdata);
        imem_ack = ack; stall = st; redirect = rd; redirect_pc = rpc; imem_rdata = rdata;
        tick();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_imem_req", 32'(imem_req), 32'(m_req()));
            chk("cyc_imem_addr", imem_addr, m_addr());
            chk("cyc_id_valid", 32'(id_valid), 32'(m_valid));
            chk("cyc_id_pc", id_pc, m_ipc);
            chk("cyc_id_instr", id_instr, m_instr);
        end
    end

    initial begin
        rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        m_reset();
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, NOP);
        rstn = 1'b1;

        // Back-to-back acks
        for (int i = 0; i < 4; i++) begin
            chk("b2b_addr", imem_addr, 32'(i * 4));
            cyc(1, 0, 0, 0, word(32'(i * 4)));
            chk("b2b_pc", id_pc, 32'(i * 4));
            chk("b2b_valid", 32'(id_valid), 32'd1);
        end

        // Two-cycle latency at 0x10
        cyc(0, 0, 0, 0, 0);
        chk("lat_addr0", imem_addr, 32'h10);
        chk("lat_bubble", 32'(id_valid), 32'd0);
        chk("lat_pc_kept", id_pc, 32'hC);
        cyc(0, 0, 0, 0, 0);
        chk("lat_addr1", imem_addr, 32'h10);
        cyc(1, 0, 0, 0, word(32'h10));
        chk("lat_pc", id_pc, 32'h10);
        chk("lat_instr", id_instr, 32'h5A00_0010);
        chk("lat_next", imem_addr, 32'h14);

        // Stall for 3 cycles coinciding with ack of 0x14
        cyc(1, 1, 0, 0, word(32'h14));
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_pc", id_pc, 32'h10);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("hold_pc2", id_pc, 32'h10);
        cyc(0, 0, 0, 0, 0);
        chk("rel_pc", id_pc, 32'h14);
        chk("rel_instr", id_instr, 32'h5A00_0014);
        chk("rel_addr", imem_addr, 32'h18);
        chk("rel_req", 32'(imem_req), 32'd1);
        cyc(1, 0, 0, 0, word(32'h18));
        chk("rel_nodup", id_pc, 32'h18);

        // Redirect while 0x1C outstanding
        cyc(0, 0, 1, 32'h103, 0);
        chk("drop_addr", imem_addr, 32'h1C);
        chk("drop_valid", 32'(id_valid), 32'd0);
        chk("drop_instr", id_instr, NOP);
        cyc(0, 0, 0, 0, 0);
        chk("drop_addr2", imem_addr, 32'h1C);
        cyc(1, 0, 0, 0, BAD);
        chk("drop_tgt", imem_addr, 32'h100);
        chk("drop_valid2", 32'(id_valid), 32'd0);
        cyc(1, 0, 0, 0, word(32'h100));
        chk("drop_first", id_pc, 32'h100);

        // Redirect + stall with the hold buffer full
        cyc(1, 1, 0, 0, word(32'h104));
        chk("hr_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 1, 32'h200, 0);
        chk("hr_valid", 32'(id_valid), 32'd0);
        chk("hr_instr", id_instr, NOP);
        chk("hr_addr", imem_addr, 32'h200);
        cyc(1, 0, 0, 0, word(32'h200));
        chk("hr_pc", id_pc, 32'h200);

        // Redirect with ack in the same cycle, then PC wrap
        cyc(1, 0, 1, 32'hFFFF_FFFE, word(32'h204));
        chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, word(32'hFFFF_FFFC));
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Redirect again while already dropping
        cyc(0, 0, 1, 32'h300, 0);
        cyc(0, 0, 1, 32'h400, 0);
        chk("dd_addr", imem_addr, 32'h0);
        cyc(1, 0, 0, 0, BAD);
        chk("dd_tgt", imem_addr, 32'h400);

        // Async reset pulse mid-request at 0x40
        cyc(1, 0, 1, 32'h40, word(32'h400));
        chk("ar_pre", imem_addr, 32'h40);
        imem_ack = 1'b0; redirect = 1'b0;
        #2;
        rstn = 1'b0;
        m_reset();
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_valid", 32'(id_valid), 32'd0);
        chk("ar_instr", id_instr, NOP);
        cyc(1, 0, 0, 0, BAD);
        rstn = 1'b1;
        imem_ack = 1'b0;
        chk("ar_first", imem_addr, 32'h0);
        cyc(1, 0, 0, 0, word(32'h0));
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_next", imem_addr, 32'h4);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit a, s, r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 2) != 0) && m_req();
            cyc(a, s, r, $urandom, m_stale ? BAD : word(m_addr()));
        end

        cyc(0, 0, 0, 0, 0);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core. It owns the architectural PC, issues requests to instruction memory over a req/ack handshake, and writes the IF/ID pipeline register. It consumes the redirect target produced by the next-PC logic in EX and honours stall and flush requests from the hazard unit. A local hold buffer absorbs an instruction that returns while IF/ID is stalled, so no memory response is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset (word aligned)
- clk  input  1  core clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- stall  input  1  hazard unit: hold IF/ID and PC
- redirect  input  1  EX resolved a taken branch/jump; also flushes IF/ID
- redirect_pc  input  32  target from next-PC logic; bits [1:0] ignored (treated as 0)
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack
- imem_ack  input  1  response valid this cycle
- imem_rdata  input  32  instruction, valid when imem_ack=1
- id_valid  output  1  IF/ID holds a real instruction
- id_pc  output  32  PC of IF/ID instruction
- id_instr  output  32  IF/ID instruction

## Operation
- States: FETCH (request outstanding), HOLD (instruction buffered, IF/ID stalled), DROP (stale request outstanding after redirect).
- Reset (async, rstn=0): state=FETCH, pc=RESET_PC, id_valid=0, id_pc=0, id_instr=`INSTR_NOP (32'h0000_0013), hold buffer empty. During reset imem_req=0; imem_addr=RESET_PC.
- FETCH: imem_req=1, imem_addr=pc.
  - ack and not stall: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay FETCH (back-to-back, one instruction per cycle if ack each cycle).
  - ack and stall: buffer <= {pc, imem_rdata}; IF/ID held; go HOLD.
  - no ack and not stall: id_valid <= 0 (bubble), id_pc/id_instr unchanged.
  - no ack and stall: IF/ID held.
- HOLD: imem_req=0. When stall=0: IF/ID <= buffer with valid=1; pc <= buffered pc+4; go FETCH.
- DROP: imem_req=1, imem_addr = address of stale request (held stable). On ack: discard rdata, go FETCH at current pc. IF/ID valid stays 0.
- Redirect (highest priority, any state): pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0, id_instr <= NOP regardless of stall; hold buffer discarded.
  - In FETCH without ack same cycle: go DROP (stale address latched).
  - In FETCH with ack same cycle: discard rdata, stay FETCH.
  - In HOLD: go FETCH.
  - In DROP: update pc, stay DROP; ack same cycle returns to FETCH.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Request at address A acked in cycle k: id_valid=1, id_pc=A at k+1; imem_addr=A+4 at k+1.
- Redirect in cycle N with no outstanding request: imem_addr=target at N+1, id_valid=0 at N+1; earliest target instruction in IF/ID at N+2.
- Stall applies in the same cycle it is asserted: IF/ID and PC do not change on that edge.
- Stall released in HOLD at cycle M: buffered instruction in IF/ID at M+1, next request issued at M+1.
- Reset mid-request: any in-flight response is ignored; first request after rstn rises is RESET_PC.

## Structure
- `INSTR_NOP and fetch state encodings (FETCH/HOLD/DROP) go in the shared ctrl_encode_def.v header.
- One natural sub-module: if_id_reg (valid/pc/instr register with load, hold, flush-to-NOP).

## Test plan
- Reset release, memory acks every cycle, RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles; id_pc 0,4,8 one cycle later, id_valid=1 continuously.
- Ack with 2-cycle latency -> imem_addr stable at 0 for 3 cycles; id_valid=0 bubbles, then id_pc=0 valid one cycle after ack.
- stall=1 for 3 cycles coinciding with ack of 0x8 -> HOLD, imem_req=0, IF/ID keeps 0x4; after release id_pc=0x8, next imem_addr=0xC, no duplicate or lost instruction.
- redirect with redirect_pc=0x103 while request for 0x10 outstanding and unacked -> imem_addr stays 0x10 until ack, response discarded, then imem_addr=0x100; id_valid=0 throughout.
- redirect and stall same cycle with HOLD buffer full -> id_valid=0, id_instr=0x0000_0013, buffer discarded, next fetch at target.
- Async rstn pulse mid-request at pc=0x40 -> outputs at reset values immediately; first post-reset imem_addr=RESET_PC.
